// File: rtl/matrix_stream_adapter.sv
// Serial front end for the 4x4 matrix add/sub unit: assembles two 16-element
// operands from a 16-bit stream, strobes the unit, then streams the result out.
module matrix_stream_adapter (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  in_data,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  out_data,
  output logic         out_last,
  output logic         busy,
  output logic [255:0] m1,
  output logic [255:0] m2,
  output logic         select_op,
  output logic         alu_enable,
  input  logic [255:0] alu_result
);

  localparam int WORD_W = 16;
  localparam int DIM    = 4;
  localparam int BUS_W  = DIM * DIM * WORD_W;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [4:0]         count_r;
  logic [4:0]         count_next_s;
  logic [BUS_W-1:0]   m1_r;
  logic [BUS_W-1:0]   m2_r;
  logic [BUS_W-1:0]   result_r;
  logic               select_op_r;
  logic               alu_enable_r;
  logic               out_valid_r;
  logic               out_last_r;
  logic [WORD_W-1:0]  out_data_r;
  logic               in_ready_s;
  logic               in_xfer_s;
  logic               out_xfer_s;

  // Element idx of a packed 16-element bus (element k at bits [k*16+15:k*16]).
  function automatic logic [WORD_W-1:0] get_elem(input logic [BUS_W-1:0] bus,
                                                 input logic [3:0] idx);
    return bus[{idx, 4'd0} +: WORD_W];
  endfunction

  assign in_ready_s = (state_r == ST_LOAD);
  assign in_xfer_s  = in_valid && in_ready_s;
  assign out_xfer_s = out_valid_r && out_ready;

  // Next-state and shared element counter.
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    case (state_r)
      ST_LOAD: begin
        if (in_xfer_s && (count_r == 5'd31)) begin
          state_next_s = ST_EXEC;
          count_next_s = 5'd0;
        end else if (in_xfer_s) begin
          count_next_s = count_r + 5'd1;
        end else begin
          count_next_s = count_r;
        end
      end
      ST_EXEC:  state_next_s = ST_WAIT;
      ST_WAIT:  state_next_s = ST_DRAIN;
      ST_DRAIN: begin
        if (out_xfer_s && (count_r == 5'd15)) begin
          state_next_s = ST_LOAD;
          count_next_s = 5'd0;
        end else if (out_xfer_s) begin
          count_next_s = count_r + 5'd1;
        end else begin
          count_next_s = count_r;
        end
      end
      default: begin
        state_next_s = ST_LOAD;
        count_next_s = 5'd0;
      end
    endcase
  end

  // State, operand assembly, result capture and registered output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_LOAD;
      count_r      <= 5'd0;
      m1_r         <= '0;
      m2_r         <= '0;
      result_r     <= '0;
      select_op_r  <= 1'b0;
      alu_enable_r <= 1'b0;
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      out_data_r   <= 16'd0;
    end else begin
      state_r      <= state_next_s;
      count_r      <= count_next_s;
      alu_enable_r <= (state_next_s == ST_EXEC) || (state_next_s == ST_WAIT);
      if (in_xfer_s) begin
        if (count_r[4]) begin
          m2_r[{count_r[3:0], 4'd0} +: WORD_W] <= in_data;
        end else begin
          m1_r[{count_r[3:0], 4'd0} +: WORD_W] <= in_data;
        end
        if (count_r == 5'd0) begin
          select_op_r <= op_sub;
        end
      end
      // Word 0 is presented straight from the unit's bus on the capture edge.
      if (state_r == ST_WAIT) begin
        result_r    <= alu_result;
        out_valid_r <= 1'b1;
        out_data_r  <= get_elem(alu_result, 4'd0);
        out_last_r  <= 1'b0;
      end else if (out_xfer_s && (count_r == 5'd15)) begin
        out_valid_r <= 1'b0;
        out_data_r  <= 16'd0;
        out_last_r  <= 1'b0;
      end else if (out_xfer_s) begin
        out_data_r  <= get_elem(result_r, count_r[3:0] + 4'd1);
        out_last_r  <= (count_r == 5'd14);
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign busy       = !((state_r == ST_LOAD) && (count_r == 5'd0));
  assign m1         = m1_r;
  assign m2         = m2_r;
  assign select_op  = select_op_r;
  assign alu_enable = alu_enable_r;
  assign out_valid  = out_valid_r;
  assign out_last   = out_last_r;
  assign out_data   = out_data_r;

endmodule
